// File: rtl/math_adder_chunked_serial.sv
`default_nettype none
// ============================================================================
// Module   : math_cla / math_adder_chunked_serial
// Purpose  : Multi-cycle wide adder. DW-bit operands are split into CW-bit
//            chunks and added LSB-first, one chunk per clock, through a single
//            CW-bit carry-lookahead adder. The inter-chunk carry is held in a
//            register. Valid/ready handshakes on both operand and result side.
// Ports    : i_clk    clock
//            i_rst    synchronous reset, active high
//            i_valid  operand request valid      o_ready  operands accepted
//            i_a/i_b  DW-bit operands            i_c      carry in
//            o_valid  result valid               i_ready  result accepted
//            o_sum    (i_a + i_b + i_c) mod 2^DW o_carry  carry out of bit DW-1
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// N-bit carry-lookahead adder. Every carry is a flat sum-of-products of the
// generate/propagate terms and the carry in, so no carry ripples bit to bit.
// ----------------------------------------------------------------------------
module math_cla #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_c,
    output logic [N-1:0] o_sum,
    output logic         o_carry
);

    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N:0]   w_c;

    assign w_g    = i_a & i_b;
    assign w_p    = i_a ^ i_b;
    assign w_c[0] = i_c;

    for (genvar i = 0; i < N; i++) begin : g_carry
        logic w_ci;
        logic w_term;

        // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..1]g[0] | p[i..0]c0
        always_comb begin
            w_term = 1'b0;
            w_ci   = i_c & (&w_p[i:0]);
            for (int j = 0; j <= i; j++) begin
                w_term = w_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    w_term = w_term & w_p[k];
                end
                w_ci = w_ci | w_term;
            end
        end

        assign w_c[i+1] = w_ci;
    end

    assign o_sum   = w_p ^ w_c[N-1:0];
    assign o_carry = w_c[N];

endmodule

// ----------------------------------------------------------------------------
// Chunk-serial adder top level.
// ----------------------------------------------------------------------------
module math_adder_chunked_serial #(
    parameter int DW = 32,
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_c,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_sum,
    output logic          o_carry
);

    // Guarded so an illegal CW=0 reaches the parameter check below instead
    // of failing earlier on a divide by zero.
    localparam int c_CW_SAFE = (CW >= 1) ? CW : 1;
    localparam int c_NCHUNK  = DW / c_CW_SAFE;
    localparam int c_IDXW    = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;

    localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(c_NCHUNK - 1);
    localparam logic [c_IDXW-1:0] c_IDX_ONE  = c_IDXW'(1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    if (CW < 1 || CW > DW || (DW % c_CW_SAFE) != 0) begin : g_bad_params
        $error("math_adder_chunked_serial: need 1 <= CW <= DW and DW %% CW == 0");
    end

    logic [1:0]        r_state;
    logic [c_IDXW-1:0] r_idx;
    logic [DW-1:0]     r_a;
    logic [DW-1:0]     r_b;
    logic [DW-1:0]     r_result;
    logic              r_carry;

    logic [31:0]       w_base;
    logic [CW-1:0]     w_a_chunk;
    logic [CW-1:0]     w_b_chunk;
    logic [CW-1:0]     w_chunk_sum;
    logic              w_chunk_carry;
    logic [DW-1:0]     w_result_next;

    assign w_base    = 32'(r_idx) * 32'(CW);
    assign w_a_chunk = r_a[w_base +: CW];
    assign w_b_chunk = r_b[w_base +: CW];

    math_cla #(
        .N (CW)
    ) u_cla (
        .i_a     (w_a_chunk),
        .i_b     (w_b_chunk),
        .i_c     (r_carry),
        .o_sum   (w_chunk_sum),
        .o_carry (w_chunk_carry)
    );

    // Result register with the current chunk merged in; on the last chunk
    // this is the complete sum, which is loaded straight into o_sum.
    always_comb begin
        w_result_next                = r_result;
        w_result_next[w_base +: CW]  = w_chunk_sum;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= c_S_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            o_ready  <= 1'b1;
            o_valid  <= 1'b0;
            o_sum    <= '0;
            o_carry  <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    // o_ready is always high here, so i_valid alone is the handshake.
                    if (i_valid) begin
                        r_a      <= i_a;
                        r_b      <= i_b;
                        r_carry  <= i_c;
                        r_idx    <= '0;
                        r_result <= '0;
                        o_ready  <= 1'b0;
                        r_state  <= c_S_RUN;
                    end
                end
                c_S_RUN: begin
                    r_result <= w_result_next;
                    r_carry  <= w_chunk_carry;
                    r_idx    <= r_idx + c_IDX_ONE;
                    if (r_idx == c_LAST_IDX) begin
                        o_sum   <= w_result_next;
                        o_carry <= w_chunk_carry;
                        o_valid <= 1'b1;
                        r_state <= c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    // o_sum/o_carry are left untouched so they persist after hand-off.
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
